// File: rtl/lc4_pipe_cla_if.sv
// rtl/lc4_pipe_cla_if.sv - operand/result handshake bundle for the pipelined CLA add/subtract unit
interface lc4_pipe_cla_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/lc4_pipe_cla.sv
// rtl/lc4_pipe_cla.sv - pipelined carry-lookahead add/subtract, one S-bit slice per stage
module lc4_pipe_cla #(
  parameter int W      = 16,
  parameter int STAGES = 4
) (
  input logic           clk,
  input logic           rst,
  lc4_pipe_cla_if.slave bus
);
  localparam int S = W / STAGES;

  logic         adv;
  logic [W-1:0] bb_in;
  logic         c0_in;

  assign bb_in = bus.sub ? ~bus.b : bus.b;
  assign c0_in = bus.sub | bus.cin;

  // Each carry is a flat sum of generate terms gated by the propagates above them.
  function automatic logic [S:0] cla_slice(input logic [S-1:0] x, input logic [S-1:0] y,
                                           input logic ci);
    logic [S-1:0] g;
    logic [S-1:0] p;
    logic [S:0]   c;
    logic         t;
    g    = x & y;
    p    = x | y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < S; i++) begin
      t = ci;
      for (int m = 0; m <= i; m++) t = t & p[m];
      c[i+1] = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) t = t & p[m];
        c[i+1] = c[i+1] | t;
      end
    end
    return {c[S], x ^ y ^ c[S-1:0]};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic         v_src;
    logic         c_src;
    logic [W-1:0] a_src;
    logic [W-1:0] bb_src;
    logic [W-1:0] res_src;
    logic [W-1:0] res_d;
    logic [S:0]   slice;
    logic         valid_q;
    logic         carry_q;
    logic [W-1:0] a_q;
    logic [W-1:0] bb_q;
    logic [W-1:0] res_q;

    if (k == 0) begin : g_head
      assign v_src   = bus.in_valid;
      assign a_src   = bus.a;
      assign bb_src  = bb_in;
      assign c_src   = c0_in;
      assign res_src = '0;
    end else begin : g_body
      assign v_src   = g_stage[k-1].valid_q;
      assign a_src   = g_stage[k-1].a_q;
      assign bb_src  = g_stage[k-1].bb_q;
      assign c_src   = g_stage[k-1].carry_q;
      assign res_src = g_stage[k-1].res_q;
    end

    assign slice = cla_slice(a_src[k*S +: S], bb_src[k*S +: S], c_src);

    always_comb begin
      res_d            = res_src;
      res_d[k*S +: S]  = slice[S-1:0];
    end

    // Global stall: every stage holds together, so bubbles keep their slots.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        a_q     <= '0;
        bb_q    <= '0;
        res_q   <= '0;
      end else if (adv) begin
        valid_q <= v_src;
        carry_q <= slice[S];
        a_q     <= a_src;
        bb_q    <= bb_src;
        res_q   <= res_d;
      end
    end
  end

  logic unused_last;
  assign unused_last = ^{g_stage[STAGES-1].a_q, g_stage[STAGES-1].bb_q};

  assign bus.out_valid = g_stage[STAGES-1].valid_q;
  assign adv           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.sum       = g_stage[STAGES-1].res_q;
  assign bus.cout      = g_stage[STAGES-1].carry_q;
  assign bus.ovf       = (g_stage[STAGES-1].a_q[W-1] == g_stage[STAGES-1].bb_q[W-1]) &&
                         (g_stage[STAGES-1].res_q[W-1] != g_stage[STAGES-1].a_q[W-1]);
endmodule
